bcd_lap_counter: RTL

BCD_LAP_COUNTER -- requirements
Module: bcd_lap_counter

---
 rtl/bcd_lap_counter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/bcd_lap_counter.sv
// Multi-digit BCD up/down counter with a clock prescaler, preset load,
// sticky expiry on down-count underflow and a lap-freeze display register.
module bcd_lap_counter #(
    parameter int CLK_FREQ   = 100000000,
    parameter int TICK_HZ    = 1,
    parameter int NUM_DIGITS = 2
) (
    input  logic                      clk,
    input  logic                      init_regs,
    input  logic                      count_enabled,
    input  logic                      count_down,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   load_value,
    input  logic                      lap,
    output logic [4*NUM_DIGITS-1:0]   time_reading,
    output logic [4*NUM_DIGITS-1:0]   live_count,
    output logic                      tick,
    output logic                      wrap,
    output logic                      expired
);

    localparam int W   = 4 * NUM_DIGITS;
    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [0:0] {
        ST_LIVE = 1'b0,
        ST_LAP  = 1'b1
    } disp_state_t;

    disp_state_t     state_q;
    logic [PW-1:0]   presc_q, presc_d;
    logic [W-1:0]    live_q, live_d;
    logic [W-1:0]    lap_q;
    logic [W-1:0]    time_q;
    logic            expired_q, expired_d;
    logic            tick_q, tick_d;
    logic            wrap_q, wrap_d;

    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic bcd_all_nines(input logic [W-1:0] v);
        logic r;
        r = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd9) begin
                r = 1'b0;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Prescaler and live count next state; load beats any same-cycle tick.
    always_comb begin
        presc_d   = presc_q;
        live_d    = live_q;
        expired_d = expired_q;
        tick_d    = 1'b0;
        wrap_d    = 1'b0;
        if (load) begin
            live_d    = bcd_clamp(load_value);
            presc_d   = '0;
            expired_d = 1'b0;
        end else if (count_enabled && !expired_q) begin
            if (presc_q == PW'(DIV - 1)) begin
                presc_d = '0;
                tick_d  = 1'b1;
                if (count_down) begin
                    if (live_q == '0) begin
                        expired_d = 1'b1;
                    end else begin
                        live_d = bcd_dec(live_q);
                    end
                end else begin
                    live_d = bcd_inc(live_q);
                    wrap_d = bcd_all_nines(live_q);
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            presc_d = presc_q;
        end
    end

    // State registers plus the LIVE/LAP display FSM with a registered reading.
    always_ff @(posedge clk) begin
        if (init_regs) begin
            presc_q   <= '0;
            live_q    <= '0;
            lap_q     <= '0;
            time_q    <= '0;
            expired_q <= 1'b0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
            state_q   <= ST_LIVE;
        end else begin
            presc_q   <= presc_d;
            live_q    <= live_d;
            expired_q <= expired_d;
            tick_q    <= tick_d;
            wrap_q    <= wrap_d;
            if (load) begin
                state_q <= ST_LIVE;
                time_q  <= live_d;
            end else begin
                case (state_q)
                    ST_LIVE: begin
                        if (lap) begin
                            lap_q   <= live_q;
                            state_q <= ST_LAP;
                            time_q  <= live_q;
                        end else begin
                            time_q  <= live_d;
                        end
                    end
                    ST_LAP: begin
                        if (lap) begin
                            state_q <= ST_LIVE;
                            time_q  <= live_d;
                        end else begin
                            time_q  <= lap_q;
                        end
                    end
                    default: begin
                        state_q <= ST_LIVE;
                        time_q  <= live_d;
                    end
                endcase
            end
        end
    end

    assign time_reading = time_q;
    assign live_count   = live_q;
    assign tick         = tick_q;
    assign wrap         = wrap_q;
    assign expired      = expired_q;

endmodule
